conv_mem_host: RTL

- Responder/host end of the CONV accelerator interface.
- Owns the 64x64 input image memory and the layer result memories selected by csel.
- Drives the ready/busy start handshake and serves iaddr/caddr_rd reads. Accepts cwr writes.
- Used as a synthesizable memory subsystem and as the bench-side host; exposes a load port for the image and a debug readback port for checkers.

---
 rtl/conv_mem_host_pkg.sv | 33 +++
 rtl/conv_sp_ram.sv | 38 +++
 rtl/conv_mem_host.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/conv_mem_host_pkg.sv
// Shared constants for the CONV host memory subsystem: memory select codes,
// per-select depths and FSM states.
package conv_mem_host_pkg;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_L0K0 = 3'd1;
    localparam logic [2:0] SEL_L0K1 = 3'd2;
    localparam logic [2:0] SEL_L1K0 = 3'd3;
    localparam logic [2:0] SEL_L1K1 = 3'd4;
    localparam logic [2:0] SEL_L2   = 3'd5;

    localparam int NUM_LAYER_MEMS = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Depth of the memory behind a select code; 0 marks an invalid select so
    // any address compared against it is out of range.
    function automatic int sel_depth(input logic [2:0] sel, input int aw,
                                     input int l1_words, input int l2_words);
        case (sel)
            SEL_L0K0, SEL_L0K1: return 1 << aw;
            SEL_L1K0, SEL_L1K1: return l1_words;
            SEL_L2:             return l2_words;
            default:            return 0;
        endcase
    endfunction

endpackage

// File: rtl/conv_sp_ram.sv
// Simple RAM: one write port and two independent registered read ports.
// Read ports return the pre-write contents when hitting the address being written.
module conv_sp_ram #(
    parameter int DW    = 20,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re_a,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic          re_b,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Output registers reset to zero; the array itself is never reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (re_a) rdata_a <= mem[raddr_a];
            if (re_b) rdata_b <= mem[raddr_b];
        end
    end

endmodule

// File: rtl/conv_mem_host.sv
// Host end of the CONV accelerator interface: image memory, layer result
// memories, ready/busy start handshake, error flags and debug readback.
module conv_mem_host
    import conv_mem_host_pkg::*;
#(
    parameter int DW           = 20,
    parameter int AW           = 12,
    parameter int L1_WORDS     = 1024,
    parameter int L2_WORDS     = 2048,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          img_we,
    input  logic [AW-1:0] img_addr,
    input  logic [DW-1:0] img_wdata,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic [2:0]    csel,
    input  logic [2:0]    dbg_sel,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_rdata,
    output logic          done,
    output logic          err_timeout,
    output logic          err_sel,
    output logic [13:0]   wr_count,
    output logic [1:0]    dbg_state
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    state_e        state, state_n;
    logic [TW-1:0] tcnt;
    logic          tmo_hit, start_acc;
    logic          wr_ok, rd_ok, dbg_ok, sel_err;
    logic [2:0]    rd_sel_q, dbg_sel_q;
    logic [DW-1:0] lay_rd  [1:NUM_LAYER_MEMS];
    logic [DW-1:0] lay_dbg [1:NUM_LAYER_MEMS];
    logic [DW-1:0] img_dbg_unused;

    assign dbg_state = state;

    // Handshake: start is a one-cycle request taken in IDLE/DONE; ready is held
    // high in REQ until busy is seen high (transfer) or the timeout expires.
    // busy falling while in RUN marks completion.
    always_comb begin
        state_n   = state;
        ready     = 1'b0;
        done      = 1'b0;
        tmo_hit   = 1'b0;
        start_acc = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n   = ST_REQ;
                    start_acc = 1'b1;
                end
            end
            ST_REQ: begin
                ready = 1'b1;
                if (busy) begin
                    state_n = ST_RUN;
                end else if (tcnt == TW'(BUSY_TIMEOUT - 1)) begin
                    state_n = ST_IDLE;
                    tmo_hit = 1'b1;
                end
            end
            ST_RUN: begin
                if (!busy) state_n = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_n   = ST_REQ;
                    start_acc = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Invalid selects have depth 0, so the range check also rejects them.
    always_comb begin
        wr_ok   = cwr && (int'(caddr_wr) < sel_depth(csel, AW, L1_WORDS, L2_WORDS));
        rd_ok   = crd && (int'(caddr_rd) < sel_depth(csel, AW, L1_WORDS, L2_WORDS));
        dbg_ok  = int'(dbg_addr) < sel_depth(dbg_sel, AW, L1_WORDS, L2_WORDS);
        sel_err = (cwr && !wr_ok) || (crd && !rd_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            tcnt        <= '0;
            err_timeout <= 1'b0;
            err_sel     <= 1'b0;
            wr_count    <= '0;
            rd_sel_q    <= SEL_NONE;
            dbg_sel_q   <= SEL_NONE;
        end else begin
            state <= state_n;
            tcnt  <= (state == ST_REQ) ? tcnt + TW'(1) : '0;
            if (tmo_hit) err_timeout <= 1'b1;
            if (sel_err) err_sel <= 1'b1;
            if (start_acc) wr_count <= '0;
            else if (wr_ok && wr_count != '1) wr_count <= wr_count + 14'd1;
            if (crd) rd_sel_q <= rd_ok ? csel : SEL_NONE;
            dbg_sel_q <= dbg_ok ? dbg_sel : SEL_NONE;
        end
    end

    conv_sp_ram #(.DW(DW), .DEPTH(1 << AW), .AW(AW)) u_image (
        .clk     (clk),
        .rst     (reset),
        .we      (img_we && state == ST_IDLE),
        .waddr   (img_addr),
        .wdata   (img_wdata),
        .re_a    (1'b1),
        .raddr_a (iaddr),
        .rdata_a (idata),
        .re_b    (1'b0),
        .raddr_b (iaddr),
        .rdata_b (img_dbg_unused)
    );

    for (genvar g = 1; g <= NUM_LAYER_MEMS; g++) begin : g_layer
        localparam int DEPTH = sel_depth(3'(g), AW, L1_WORDS, L2_WORDS);
        localparam int RAW   = $clog2(DEPTH);
        conv_sp_ram #(.DW(DW), .DEPTH(DEPTH), .AW(RAW)) u_ram (
            .clk     (clk),
            .rst     (reset),
            .we      (wr_ok && csel == 3'(g)),
            .waddr   (caddr_wr[RAW-1:0]),
            .wdata   (cdata_wr),
            .re_a    (rd_ok && csel == 3'(g)),
            .raddr_a (caddr_rd[RAW-1:0]),
            .rdata_a (lay_rd[g]),
            .re_b    (dbg_sel == 3'(g)),
            .raddr_b (dbg_addr[RAW-1:0]),
            .rdata_b (lay_dbg[g])
        );
    end

    // rd_sel_q only moves on crd, so cdata_rd holds between reads.
    always_comb begin
        cdata_rd  = '0;
        dbg_rdata = '0;
        for (int i = 1; i <= NUM_LAYER_MEMS; i++) begin
            if (rd_sel_q == 3'(i)) cdata_rd = lay_rd[i];
            if (dbg_sel_q == 3'(i)) dbg_rdata = lay_dbg[i];
        end
    end

endmodule
